// File: rtl/foreground_line_scheduler.sv
// rtl/foreground_line_scheduler.sv - per-scanline foreground object scheduler (OBM scan into slot sets)
// Optional FG_SCHED_EARLY_EXIT_EN: stop the scan at the first hit found with every slot already taken.
module foreground_line_scheduler #(
    parameter int NUM_OBJECTS = 64,
    parameter int MAX_SLOTS   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [7:0]             line_y,
    input  logic                   swap,
    output logic                   obm_rd_en,
    output logic [7:0]             obm_addr,
    input  logic [7:0]             obm_data,
    output logic                   busy,
    output logic                   done,
    output logic [MAX_SLOTS-1:0]   slot_valid,
    output logic [8*MAX_SLOTS-1:0] slot_xp,
    output logic [3*MAX_SLOTS-1:0] slot_row,
    output logic [5*MAX_SLOTS-1:0] slot_pmfa,
    output logic [MAX_SLOTS-1:0]   slot_hflip,
    output logic [3*MAX_SLOTS-1:0] slot_color,
    output logic                   overflow,
    output logic                   overrun
);

    localparam int IDXW = $clog2(NUM_OBJECTS);
    localparam int CNTW = $clog2(MAX_SLOTS + 1);

    // The xp fetch is issued straight from CHECK_Y on a hit, so a committed
    // object costs three cycles beyond the two-cycle y probe.
    typedef enum logic [2:0] {
        S_IDLE,
        S_READ_Y,
        S_CHECK_Y,
        S_READ_ATTR,
        S_READ_COLOR,
        S_COMMIT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   obj_q, obj_d;
    logic [7:0]        line_q, line_d;
    logic [2:0]        row_q, row_d;
    logic [7:0]        xp_q, xp_d;
    logic [6:0]        attr_q, attr_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              wovf_q, wovf_d;
    logic [7:0]        addr_q, addr_d;
    logic              rd_en;
    logic              commit;
    logic              last_obj;
    logic              hit;
    logic              slots_free;
    logic [7:0]        y_diff;
    logic [2:0]        row_final;

    logic              w_valid_q [MAX_SLOTS];
    logic [7:0]        w_xp_q    [MAX_SLOTS];
    logic [2:0]        w_row_q   [MAX_SLOTS];
    logic [4:0]        w_pmfa_q  [MAX_SLOTS];
    logic              w_hflip_q [MAX_SLOTS];
    logic [2:0]        w_color_q [MAX_SLOTS];

    logic [MAX_SLOTS-1:0]   slot_valid_q;
    logic [8*MAX_SLOTS-1:0] slot_xp_q;
    logic [3*MAX_SLOTS-1:0] slot_row_q;
    logic [5*MAX_SLOTS-1:0] slot_pmfa_q;
    logic [MAX_SLOTS-1:0]   slot_hflip_q;
    logic [3*MAX_SLOTS-1:0] slot_color_q;
    logic                   overflow_q;
    logic                   overrun_q;

    // Nine-bit compare so objects near the bottom never wrap onto the top lines.
    assign hit        = ({1'b0, obm_data} <= {1'b0, line_q}) &&
                        ({1'b0, line_q} < ({1'b0, obm_data} + 9'd8));
    assign slots_free = (cnt_q < CNTW'(MAX_SLOTS));
    assign last_obj   = (obj_q == IDXW'(NUM_OBJECTS - 1));
    assign y_diff     = line_q - obm_data;
    assign row_final  = attr_q[5] ? (3'd7 - row_q) : row_q;

    always_comb begin
        state_d = state_q;
        obj_d   = obj_q;
        line_d  = line_q;
        row_d   = row_q;
        xp_d    = xp_q;
        attr_d  = attr_q;
        cnt_d   = cnt_q;
        wovf_d  = wovf_q;
        addr_d  = addr_q;
        rd_en   = 1'b0;
        commit  = 1'b0;

        case (state_q)
            S_IDLE: ;
            S_READ_Y: begin
                rd_en   = 1'b1;
                addr_d  = 8'({obj_q, 2'd1});
                state_d = S_CHECK_Y;
            end
            S_CHECK_Y: begin
                if (hit && slots_free) begin
                    row_d   = y_diff[2:0];
                    rd_en   = 1'b1;
                    addr_d  = 8'({obj_q, 2'd0});
                    state_d = S_READ_ATTR;
                end else begin
                    if (hit) begin
                        wovf_d = 1'b1;
                    end
`ifdef FG_SCHED_EARLY_EXIT_EN
                    if (hit || last_obj) begin
                        state_d = S_DONE;
                    end else begin
                        obj_d   = obj_q + IDXW'(1);
                        state_d = S_READ_Y;
                    end
`else
                    if (last_obj) begin
                        state_d = S_DONE;
                    end else begin
                        obj_d   = obj_q + IDXW'(1);
                        state_d = S_READ_Y;
                    end
`endif
                end
            end
            S_READ_ATTR: begin
                xp_d    = obm_data;
                rd_en   = 1'b1;
                addr_d  = 8'({obj_q, 2'd2});
                state_d = S_READ_COLOR;
            end
            S_READ_COLOR: begin
                attr_d  = obm_data[6:0];
                rd_en   = 1'b1;
                addr_d  = 8'({obj_q, 2'd3});
                state_d = S_COMMIT;
            end
            S_COMMIT: begin
                commit = 1'b1;
                cnt_d  = cnt_q + CNTW'(1);
                if (last_obj) begin
                    state_d = S_DONE;
                end else begin
                    obj_d   = obj_q + IDXW'(1);
                    state_d = S_READ_Y;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // swap abandons any scan; a same-cycle start then begins a fresh one.
        if (swap) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            wovf_d  = 1'b0;
        end
        if (start) begin
            state_d = S_READ_Y;
            obj_d   = '0;
            line_d  = line_y;
            cnt_d   = '0;
            wovf_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            obj_q        <= '0;
            line_q       <= '0;
            row_q        <= '0;
            xp_q         <= '0;
            attr_q       <= '0;
            cnt_q        <= '0;
            wovf_q       <= 1'b0;
            addr_q       <= '0;
            slot_valid_q <= '0;
            slot_xp_q    <= '0;
            slot_row_q   <= '0;
            slot_pmfa_q  <= '0;
            slot_hflip_q <= '0;
            slot_color_q <= '0;
            overflow_q   <= 1'b0;
            overrun_q    <= 1'b0;
            for (int i = 0; i < MAX_SLOTS; i++) begin
                w_valid_q[i] <= 1'b0;
                w_xp_q[i]    <= '0;
                w_row_q[i]   <= '0;
                w_pmfa_q[i]  <= '0;
                w_hflip_q[i] <= 1'b0;
                w_color_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            obj_q   <= obj_d;
            line_q  <= line_d;
            row_q   <= row_d;
            xp_q    <= xp_d;
            attr_q  <= attr_d;
            cnt_q   <= cnt_d;
            wovf_q  <= wovf_d;
            addr_q  <= addr_d;

            if (swap) begin
                overflow_q <= wovf_q;
                overrun_q  <= busy;
                for (int i = 0; i < MAX_SLOTS; i++) begin
                    slot_valid_q[i]       <= w_valid_q[i];
                    slot_xp_q[8*i +: 8]   <= w_valid_q[i] ? w_xp_q[i]    : 8'd0;
                    slot_row_q[3*i +: 3]  <= w_valid_q[i] ? w_row_q[i]   : 3'd0;
                    slot_pmfa_q[5*i +: 5] <= w_valid_q[i] ? w_pmfa_q[i]  : 5'd0;
                    slot_hflip_q[i]       <= w_valid_q[i] & w_hflip_q[i];
                    slot_color_q[3*i +: 3] <= w_valid_q[i] ? w_color_q[i] : 3'd0;
                end
            end

            for (int i = 0; i < MAX_SLOTS; i++) begin
                if (swap || start) begin
                    w_valid_q[i] <= 1'b0;
                    w_xp_q[i]    <= '0;
                    w_row_q[i]   <= '0;
                    w_pmfa_q[i]  <= '0;
                    w_hflip_q[i] <= 1'b0;
                    w_color_q[i] <= '0;
                end else if (commit && (cnt_q == CNTW'(i))) begin
                    w_valid_q[i] <= 1'b1;
                    w_xp_q[i]    <= xp_q;
                    w_row_q[i]   <= row_final;
                    w_pmfa_q[i]  <= attr_q[4:0];
                    w_hflip_q[i] <= attr_q[6];
                    w_color_q[i] <= obm_data[2:0];
                end
            end
        end
    end

    assign obm_rd_en  = rd_en;
    assign obm_addr   = addr_d;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign slot_valid = slot_valid_q;
    assign slot_xp    = slot_xp_q;
    assign slot_row   = slot_row_q;
    assign slot_pmfa  = slot_pmfa_q;
    assign slot_hflip = slot_hflip_q;
    assign slot_color = slot_color_q;
    assign overflow   = overflow_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_foreground_line_scheduler.sv
// tb/tb_foreground_line_scheduler.sv - randomized and directed bench for foreground_line_scheduler
module tb_foreground_line_scheduler;

    localparam int N = 64;
    localparam int S = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [7:0]     line_y;
    logic           swap;
    logic           obm_rd_en;
    logic [7:0]     obm_addr;
    logic [7:0]     obm_data = 8'd0;
    logic           busy;
    logic           done;
    logic [S-1:0]   slot_valid;
    logic [8*S-1:0] slot_xp;
    logic [3*S-1:0] slot_row;
    logic [5*S-1:0] slot_pmfa;
    logic [S-1:0]   slot_hflip;
    logic [3*S-1:0] slot_color;
    logic           overflow;
    logic           overrun;

    foreground_line_scheduler #(.NUM_OBJECTS(N), .MAX_SLOTS(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .line_y     (line_y),
        .swap       (swap),
        .obm_rd_en  (obm_rd_en),
        .obm_addr   (obm_addr),
        .obm_data   (obm_data),
        .busy       (busy),
        .done       (done),
        .slot_valid (slot_valid),
        .slot_xp    (slot_xp),
        .slot_row   (slot_row),
        .slot_pmfa  (slot_pmfa),
        .slot_hflip (slot_hflip),
        .slot_color (slot_color),
        .overflow   (overflow),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    logic [7:0] obm [0:255];
    int done_cnt = 0;

    always @(posedge clk) begin
        if (obm_rd_en) obm_data <= obm[obm_addr];
        if (done) done_cnt <= done_cnt + 1;
    end

    int checks   = 0;
    int failures = 0;

    logic [S-1:0]   e_valid, e_hflip;
    logic [8*S-1:0] e_xp;
    logic [3*S-1:0] e_row, e_color;
    logic [5*S-1:0] e_pmfa;
    logic           e_ovf;
    int             e_hits;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: first S objects in index order whose 8-line band contains the line.
    task automatic model(input int line);
        int c, yp, row;
        logic [7:0] attr;
        c = 0; e_ovf = 1'b0;
        e_valid = '0; e_hflip = '0; e_xp = '0; e_row = '0; e_color = '0; e_pmfa = '0;
        for (int o = 0; o < N; o++) begin
            yp = int'(obm[o*4+1]);
            if (yp <= line && line < yp + 8) begin
                if (c < S) begin
                    attr = obm[o*4+2];
                    row = line - yp;
                    if (attr[5]) row = 7 - row;
                    e_valid[c]       = 1'b1;
                    e_xp[8*c +: 8]   = obm[o*4];
                    e_row[3*c +: 3]  = row[2:0];
                    e_pmfa[5*c +: 5] = attr[4:0];
                    e_hflip[c]       = attr[6];
                    e_color[3*c +: 3] = obm[o*4+3][2:0];
                    c++;
                end else begin
                    e_ovf = 1'b1;
                end
            end
        end
        e_hits = c;
    endtask

    task automatic fill_miss(input logic [7:0] yp);
        for (int o = 0; o < N; o++) begin
            obm[o*4]   = 8'($urandom);
            obm[o*4+1] = yp;
            obm[o*4+2] = 8'($urandom);
            obm[o*4+3] = 8'($urandom);
        end
    endtask

    task automatic rand_obm(input int line, input int hit_pct);
        for (int o = 0; o < N; o++) begin
            obm[o*4]   = 8'($urandom);
            obm[o*4+2] = 8'($urandom);
            obm[o*4+3] = 8'($urandom);
            if (int'($urandom_range(0, 99)) < hit_pct)
                obm[o*4+1] = 8'(line - int'($urandom_range(0, 7)));
            else
                obm[o*4+1] = 8'($urandom);
        end
    endtask

    task automatic pulse_start(input int line);
        @(negedge clk); start = 1'b1; line_y = 8'(line);
        @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_swap();
        @(negedge clk); swap = 1'b1;
        @(negedge clk); swap = 1'b0;
    endtask

    // Called at the negedge of cycle 1 (first cycle after start was sampled).
    task automatic wait_done(input string tag, input int exp_cyc);
        int cyc;
        cyc = 1;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, "_done_cycle"}, 64'(cyc), 64'(exp_cyc));
        @(negedge clk);
        check_eq({tag, "_done_width"}, {62'd0, done, busy}, 64'd0);
    endtask

    task automatic check_active(input string tag, input logic exp_overrun);
        check_eq({tag, "_valid"},    64'(slot_valid), 64'(e_valid));
        check_eq({tag, "_xp"},       64'(slot_xp),    64'(e_xp));
        check_eq({tag, "_row"},      64'(slot_row),   64'(e_row));
        check_eq({tag, "_pmfa"},     64'(slot_pmfa),  64'(e_pmfa));
        check_eq({tag, "_hflip"},    64'(slot_hflip), 64'(e_hflip));
        check_eq({tag, "_color"},    64'(slot_color), 64'(e_color));
        check_eq({tag, "_overflow"}, 64'(overflow),   64'(e_ovf));
        check_eq({tag, "_overrun"},  64'(overrun),    64'(exp_overrun));
    endtask

    task automatic scan_and_swap(input string tag, input int line);
        model(line);
        pulse_start(line);
        wait_done(tag, 2*N + 3*e_hits + 1);
        pulse_swap();
        check_active(tag, 1'b0);
    endtask

    initial begin
        int d0, l1, l2;
        rst = 1'b1; start = 1'b0; swap = 1'b0; line_y = 8'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_slots", {slot_valid, slot_hflip, slot_row, slot_color, slot_pmfa[15:0]}, 64'd0);
        check_eq("rst_xp", 64'(slot_xp), 64'd0);
        check_eq("rst_pmfa", 64'(slot_pmfa), 64'd0);
        check_eq("rst_flags", {60'd0, overflow, overrun, busy, done}, 64'd0);

        // Single hit with vflip.
        fill_miss(8'd200);
        obm[20] = 8'd40; obm[21] = 8'd20; obm[22] = 8'h63; obm[23] = 8'd5;
        pulse_start(23);
        wait_done("obj5", 132);
        pulse_swap();
        check_eq("obj5_valid", 64'(slot_valid), 64'h01);
        check_eq("obj5_xp",    64'(slot_xp[7:0]), 64'd40);
        check_eq("obj5_row",   64'(slot_row[2:0]), 64'd4);
        check_eq("obj5_pmfa",  64'(slot_pmfa[4:0]), 64'd3);
        check_eq("obj5_hflip", 64'(slot_hflip[0]), 64'd1);
        check_eq("obj5_color", 64'(slot_color[2:0]), 64'd5);
        check_eq("obj5_flags", {62'd0, overflow, overrun}, 64'd0);

        // Ten objects on the line: only the first eight kept, overflow set.
        fill_miss(8'd200);
        for (int o = 0; o < 10; o++) obm[o*4+1] = 8'd50;
        model(52);
        pulse_start(52);
        wait_done("full", 153);
        pulse_swap();
        check_active("full", 1'b0);
        check_eq("full_ovf", 64'(overflow), 64'd1);

        // No wrap for an object near the bottom edge.
        fill_miss(8'd100);
        obm[1] = 8'd252; obm[2] = 8'h00;
        scan_and_swap("wrap3", 3);
        check_eq("wrap3_valid", 64'(slot_valid), 64'd0);
        scan_and_swap("wrap255", 255);
        check_eq("wrap255_row", {61'd0, slot_row[2:0]}, 64'd3);

        // swap during the scan: partial slots published, scan abandoned.
        fill_miss(8'd200);
        obm[1] = 8'd10; obm[5] = 8'd10;
        model(12);
        d0 = done_cnt;
        pulse_start(12);
        repeat (48) @(negedge clk);
        pulse_swap();
        check_active("ovr", 1'b1);
        check_eq("ovr_busy", 64'(busy), 64'd0);
        repeat (150) @(negedge clk);
        check_eq("ovr_no_done", 64'(done_cnt), 64'(d0));

        // start while busy restarts from object 0.
        rand_obm(77, 15);
        pulse_start(30);
        repeat (20) @(negedge clk);
        model(77);
        pulse_start(77);
        wait_done("restart", 2*N + 3*e_hits + 1);
        pulse_swap();
        check_active("restart", 1'b0);

        // start and swap together after a completed scan.
        l1 = int'($urandom_range(0, 255));
        l2 = int'($urandom_range(0, 255));
        rand_obm(l1, 20);
        for (int o = 0; o < N; o += 3) obm[o*4+1] = 8'(l2 - int'($urandom_range(0, 7)));
        model(l1);
        pulse_start(l1);
        wait_done("ss_first", 2*N + 3*e_hits + 1);
        @(negedge clk); start = 1'b1; swap = 1'b1; line_y = 8'(l2);
        @(negedge clk); start = 1'b0; swap = 1'b0;
        check_active("ss_prev", 1'b0);
        model(l2);
        wait_done("ss_next", 2*N + 3*e_hits + 1);
        pulse_swap();
        check_active("ss_next", 1'b0);

        // Randomized scans with varying hit density.
        for (int it = 0; it < 12; it++) begin
            l1 = int'($urandom_range(0, 255));
            rand_obm(l1, int'($urandom_range(0, 30)));
            scan_and_swap($sformatf("rnd%0d", it), l1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
